// File: rtl/rfdbg_pkg.sv
// Shared definitions for the debug register-file access block.
// Optional feature macro used by the block: RFDBG_DUMP_EN (multi-register dump).
package rfdbg_pkg;

   localparam int          RF_ADDR_W   = 5;
   localparam logic [4:0]  RF_LAST_IDX = 5'd31;

   // Access sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } rfdbg_state_e;

endpackage

// File: rtl/regfile_dbg_access.sv
// Debug initiator for the core register file: takes a host read/write command,
// stalls the core with dbg_hold, performs one regfile access once the core is
// at an instruction boundary, and returns the result on a valid/ready channel.
// Macro RFDBG_DUMP_EN: a read with cmd_dump=1 walks cmd_addr..31, one response
// per index. Without it cmd_dump is ignored and rsp_last is tied high.
module regfile_dbg_access
   import rfdbg_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic                 cmd_dump,
   input  logic [RF_ADDR_W-1:0] cmd_addr,
   input  logic [WIDTH-1:0]     cmd_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [RF_ADDR_W-1:0] rsp_addr,
   output logic [WIDTH-1:0]     rsp_rdata,
   output logic                 rsp_last,
   input  logic                 core_idle,
   output logic                 dbg_hold,
   output logic [RF_ADDR_W-1:0] rf_ra,
   input  logic [WIDTH-1:0]     rf_rd,
   output logic [RF_ADDR_W-1:0] rf_wa,
   output logic [WIDTH-1:0]     rf_wd,
   output logic                 rf_we
);

   rfdbg_state_e         state_q, state_d;
   logic [RF_ADDR_W-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]     wdata_q, wdata_d;
   logic                 write_q, write_d;
   logic [WIDTH-1:0]     rdata_q, rdata_d;
   logic                 dump_q, dump_d;
   logic                 dump_more;
   logic                 dump_take;

`ifdef RFDBG_DUMP_EN
   // A dump is only meaningful for reads; a dump-write degrades to one write.
   assign dump_take = cmd_dump & ~cmd_write;
   assign dump_more = dump_q && (addr_q != RF_LAST_IDX);
   assign rsp_last  = !dump_q || (addr_q == RF_LAST_IDX);
`else
   logic unused_dump;
   assign unused_dump = cmd_dump;
   assign dump_take   = 1'b0;
   assign dump_more   = 1'b0;
   assign rsp_last    = 1'b1;
`endif

   // Next-state, command latch and response capture
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      rdata_d = rdata_q;
      dump_d  = dump_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               write_d = cmd_write;
               dump_d  = dump_take;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (core_idle) state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            // Writes echo the value stored; r0 is never written so it echoes 0.
            if (write_q) rdata_d = (addr_q == '0) ? '0 : wdata_q;
            else         rdata_d = rf_rd;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               if (dump_more) begin
                  addr_d  = addr_q + RF_ADDR_W'(1);
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
         dump_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
         dump_q  <= dump_d;
      end
   end

   // Handshakes and strobes decode straight from the state register so an
   // async reset drops them immediately.
   assign cmd_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign dbg_hold  = (state_q != ST_IDLE);
   assign rf_we     = (state_q == ST_ACCESS) && write_q && (addr_q != '0);
   assign rf_ra     = addr_q;
   assign rf_wa     = addr_q;
   assign rf_wd     = wdata_q;
   assign rsp_addr  = addr_q;
   assign rsp_rdata = rdata_q;

endmodule
